// File: rtl/mat_vec_loader.sv
// mat_vec_loader: assembles a streamed frame of Mdata*Ndata matrix elements followed
// by Ndata vector elements into parallel M/X registers, with framing-error detection.
`default_nettype none

module mat_vec_loader #(
  parameter int Mdata = 4,
  parameter int Ndata = 4,
  parameter int Nbits = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [Nbits-1:0]             in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [Mdata*Ndata*Nbits-1:0] M,
  output logic [Ndata*Nbits-1:0]       X,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         err
);

  localparam int MN = Mdata * Ndata;
  localparam int F  = MN + Ndata;
  localparam int CW = (F > 1) ? $clog2(F) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_M = 2'd1,
    S_LOAD_X = 2'd2,
    S_FULL   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic [MN*Nbits-1:0]      m_q;
  logic [Ndata*Nbits-1:0]   x_q;

  logic w_accept;
  logic w_last_idx;
  logic w_frame_err;

  assign in_ready    = (state_q == S_LOAD_M) || (state_q == S_LOAD_X);
  assign out_valid   = (state_q == S_FULL);
  assign err         = err_q;
  assign M           = m_q;
  assign X           = x_q;

  assign w_accept    = in_valid && in_ready;
  assign w_last_idx  = (cnt_q == CW'(F - 1));
  // in_last must be set on exactly the final element of the frame
  assign w_frame_err = w_accept && (in_last != w_last_idx);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_LOAD_M;
      S_LOAD_M, S_LOAD_X: begin
        if (w_frame_err) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_LOAD_M;
        end else if (w_accept) begin
          if (w_last_idx) begin
            cnt_d   = '0;
            state_d = S_FULL;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (state_q == S_LOAD_M && cnt_q == CW'(MN - 1)) begin
              state_d = S_LOAD_X;
            end
          end
        end
      end
      S_FULL: begin
        if (out_ready) begin
          state_d = S_LOAD_M;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // The element counter alone selects the destination slot in M or X
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      x_q <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < MN; k++) begin
        if (cnt_q == CW'(k)) begin
          m_q[k*Nbits +: Nbits] <= in_data;
        end
      end
      for (int k = 0; k < Ndata; k++) begin
        if (cnt_q == CW'(MN + k)) begin
          x_q[k*Nbits +: Nbits] <= in_data;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mat_vec_loader.sv
// tb_mat_vec_loader: directed plus randomized frames checked against a queue-based
// reference model of the frame rules (Mdata=2, Ndata=2, Nbits=8, F=6).
`default_nettype none

module tb_mat_vec_loader;

  localparam int MD = 2;
  localparam int ND = 2;
  localparam int NB = 8;
  localparam int MN = MD * ND;
  localparam int F  = MN + ND;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NB-1:0]         in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [MN*NB-1:0]      M;
  logic [ND*NB-1:0]      X;
  logic                  out_valid;
  logic                  out_ready;
  logic                  err;

  mat_vec_loader #(.Mdata(MD), .Ndata(ND), .Nbits(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .M         (M),
    .X         (X),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: elements accepted so far in the current frame
  logic [NB-1:0]    acc[$];
  logic [MN*NB-1:0] exp_m;
  logic [ND*NB-1:0] exp_x;
  logic [NB-1:0]    fd[F];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_M"}, 64'(M), 64'd0);
    check({tag, "_X"}, 64'(X), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  // Entered at a negedge; returns at a negedge with the reset released.
  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = NB'($urandom);
    in_last  = 1'($urandom);
    #1;
    check_reset_outputs("rst_async");
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    acc.delete();
    #1;
    check("rst_release_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  // st: 0 = mid-frame, 1 = frame complete, 2 = framing error, 3 = timeout
  task automatic send(input logic [NB-1:0] d, input logic last, input int gap, output int st);
    int w;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_data  = NB'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      st = 3;
      return;
    end
    @(posedge clk);
    acc.push_back(d);
    st = 0;
    if (last || acc.size() == F) begin
      if (last && acc.size() == F) begin
        st = 1;
        exp_m = '0;
        exp_x = '0;
        for (int k = 0; k < MN; k++) exp_m[k*NB +: NB] = acc[k];
        for (int k = 0; k < ND; k++) exp_x[k*NB +: NB] = acc[MN + k];
      end else begin
        st = 2;
      end
      acc.delete();
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("err", 64'(err), 64'(st == 2));
    check("out_valid", 64'(out_valid), 64'(st == 1));
    if (st == 1) begin
      check("M", 64'(M), 64'(exp_m));
      check("X", 64'(X), 64'(exp_x));
      check("full_in_ready", 64'(in_ready), 64'd0);
    end
  endtask

  // Hold out_ready low for 'hold' cycles with junk on the input, then consume.
  task automatic consume(input int hold);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = NB'($urandom);
      in_last   = 1'($urandom);
      @(negedge clk);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_M", 64'(M), 64'(exp_m));
      check("hold_X", 64'(X), 64'(exp_x));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("consumed_out_valid", 64'(out_valid), 64'd0);
    check("consumed_in_ready", 64'(in_ready), 64'd1);
  endtask

  // kind 0 = good, 1 = early in_last at errpos, 2 = missing in_last.
  // gapmode 0 = back-to-back, 1 = random gaps, 2 = alternating gaps.
  // hold < 0 resets the DUT in FULL instead of consuming.
  task automatic run_frame(input int kind, input int errpos, input int gapmode, input int hold);
    int st;
    int n;
    int gap;
    logic last;
    n = (kind == 1) ? errpos + 1 : F;
    st = 0;
    for (int k = 0; k < n; k++) begin
      case (gapmode)
        1:       gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        2:       gap = 1;
        default: gap = 0;
      endcase
      case (kind)
        1:       last = (k == errpos);
        2:       last = 1'b0;
        default: last = (k == F - 1);
      endcase
      send(fd[k], last, gap, st);
      if (st == 3) return;
    end
    if (st == 1) begin
      if (hold < 0) do_reset();
      else consume(hold);
    end
  endtask

  task automatic set_frame(input logic [NB-1:0] base);
    for (int k = 0; k < F; k++) fd[k] = base + NB'(k);
  endtask

  task automatic rand_frame();
    for (int k = 0; k < F; k++) fd[k] = NB'($urandom);
  endtask

  initial begin
    int st;
    int r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    set_frame(8'h01); run_frame(0, 0, 0, 0);   // basic frame
    set_frame(8'h01); run_frame(0, 0, 0, 5);   // backpressure
    set_frame(8'h21); run_frame(1, 3, 0, 0);   // early in_last
    set_frame(8'h11); run_frame(0, 0, 0, 0);
    set_frame(8'h31); run_frame(2, 0, 0, 0);   // missing in_last
    set_frame(8'h41); run_frame(0, 0, 0, 1);
    set_frame(8'h01); run_frame(0, 0, 2, 0);   // in_valid gaps

    // reset after three elements, then a clean frame
    set_frame(8'h51);
    for (int k = 0; k < 3; k++) send(fd[k], 1'b0, 0, st);
    do_reset();
    set_frame(8'h61); run_frame(0, 0, 0, 0);
    set_frame(8'h71); run_frame(0, 0, 0, -1);  // reset while FULL
    set_frame(8'h81); run_frame(0, 0, 1, 2);

    for (int i = 0; i < 60; i++) begin
      rand_frame();
      r = int'($urandom_range(0, 9));
      if (r < 6)      run_frame(0, 0, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)));
      else if (r < 8) run_frame(1, int'($urandom_range(0, F - 2)), int'($urandom_range(0, 1)), 0);
      else            run_frame(2, 0, int'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule

`default_nettype wire
